fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter bW, default 32: data width in bits.
REQ-002 SHALL have parameter eC, default 16: entry count of the attached storage; eC >= 2, need not be a power of two.
REQ-003 SHALL have parameter aW, default $clog2(eC): storage address width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, bW): upstream push handshake.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, bW): downstream pop handshake.
REQ-008 SHALL have ports writeAddr (output, aW), writeData (output, bW) and writeEn (output, 1): storage write side.
REQ-009 SHALL have ports readAddr (output, aW) and readData (input, bW): storage read side; readData is combinational from readAddr.
REQ-010 SHALL have port level (output, aW+1): current occupancy, 0..eC.
REQ-011 SHALL have ports full (output, 1) and empty (output, 1): status flags.

Function
REQ-012 SHALL hold state: wr_ptr and rd_ptr (aW bits each) and count (aW+1 bits).
REQ-013 SHALL drive full = (count == eC), empty = (count == 0) and level = count.
REQ-014 SHALL drive in_ready = !full; push = in_valid && in_ready.
REQ-015 SHALL drive out_valid = !empty; pop = out_valid && out_ready.
REQ-016 SHALL drive writeEn = push, writeAddr = wr_ptr and writeData = in_data, all combinational; the storage commits on the same edge.
REQ-017 SHALL drive readAddr = rd_ptr and out_data = readData, combinational; the head entry is presented with zero added latency.
REQ-018 SHALL, on push, advance wr_ptr by 1, wrapping eC-1 -> 0 explicitly (not by natural overflow).
REQ-019 SHALL, on pop, advance rd_ptr by 1 with the same eC-1 -> 0 wrap.
REQ-020 SHALL update count by push only: +1; pop only: -1; both or neither: unchanged.
REQ-021 SHALL, when full, deassert in_ready; push is blocked even if a pop occurs in the same cycle (no full-bypass); in_ready reasserts the cycle after the pop.
REQ-022 SHALL, when empty, deassert out_valid; a push in that cycle does not appear at out_data until the next cycle (no empty-bypass; latency in->out = 1 cycle).
REQ-023 SHALL make out_data stable while out_valid && !out_ready, because rd_ptr does not move.
REQ-024 SHALL keep in_ready independent of in_valid, and out_valid independent of out_ready (no combinational loops through the handshakes).
REQ-025 SHALL leave count in 0..eC at all times; overflow and underflow are unreachable by construction.

Reset
REQ-026 SHALL, on a clk edge with rst_n == 0, set wr_ptr = 0, rd_ptr = 0 and count = 0, giving empty = 1, full = 0, level = 0, in_ready = 1 and out_valid = 0.
REQ-027 SHALL, during reset, force writeEn = 0 regardless of in_valid.
REQ-028 SHALL, when reset is asserted mid-operation, discard all queued entries; storage contents are not cleared and are treated as stale.
REQ-029 SHALL make the first push be accepted on the first edge after rst_n returns to 1.

Verification (bW=8, eC=4 unless stated)
REQ-030 SHALL cover fill/drain: push 0x11, 0x22, 0x33, 0x44 with out_ready=0 -> full=1, level=4, in_ready=0; then out_ready=1 -> out_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then empty=1.
REQ-031 SHALL cover wrap: 6 pushes interleaved with pops at eC=3 -> wr_ptr sequence 0,1,2,0,1,2, with data in order and no loss.
REQ-032 SHALL cover simultaneous push/pop: at level=2, in_valid=out_ready=1 for 5 cycles -> level stays 2, in-order output, writeEn=1 every cycle.
REQ-033 SHALL cover full plus pop: at level=4, in_valid=1 and out_ready=1 -> that cycle pops only, level=3; next cycle push accepted, level=4.
REQ-034 SHALL cover empty plus push: at level=0, push 0x5A -> out_valid=0 that cycle, then out_valid=1 with out_data=0x5A the next cycle.
REQ-035 SHALL cover reset mid-operation: at level=3, rst_n=0 for 1 cycle with in_valid=1 -> writeEn=0, then level=0, empty=1, in_ready=1.

Source files
------------

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller driving an external storage array that
// has a combinational read port. It adds no bypass paths in either direction.
module fifo_ctrl #(
  parameter int bW = 32,
  parameter int eC = 16,
  parameter int aW = $clog2(eC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [bW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [bW-1:0] out_data,
  output logic [aW-1:0] writeAddr,
  output logic [bW-1:0] writeData,
  output logic          writeEn,
  output logic [aW-1:0] readAddr,
  input  logic [bW-1:0] readData,
  output logic [aW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [aW-1:0] PTR_LAST = aW'(eC - 1);
  localparam logic [aW:0]   CNT_FULL = (aW + 1)'(eC);

  logic [aW-1:0] wr_ptr_q, wr_ptr_d;
  logic [aW-1:0] rd_ptr_q, rd_ptr_d;
  logic [aW:0]   count_q,  count_d;
  logic          push_s;
  logic          pop_s;

  // Status flags and handshakes come from count alone, so neither ready nor valid loops back through the other side.
  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    level     = count_q;
    in_ready  = !full;
    out_valid = !empty;
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
    writeEn   = push_s && rst_n;
    writeAddr = wr_ptr_q;
    writeData = in_data;
    readAddr  = rd_ptr_q;
    out_data  = readData;
  end

  // Next-state computation. The pointers wrap explicitly because eC need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + aW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + aW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (aW + 1)'(1);
      2'b01:   count_d = count_q - (aW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers. Reset empties the queue; whatever is left in storage is stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl. It uses an eC=4 instance for most scenarios and an eC=3 instance for pointer wrap.
// Each DUT drives a behavioural storage array that has a combinational read port.
module tb_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // eC = 4 instance
  logic       rst_n, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, w_en, full, empty;
  logic [7:0] out_data, w_data, r_data;
  logic [1:0] w_addr, r_addr;
  logic [2:0] level;
  logic [7:0] mem4 [4];

  fifo_ctrl #(.bW(8), .eC(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .writeAddr(w_addr), .writeData(w_data), .writeEn(w_en),
    .readAddr(r_addr), .readData(r_data),
    .level(level), .full(full), .empty(empty)
  );

  // Storage model for the eC=4 instance
  always_ff @(posedge clk) begin
    if (w_en) mem4[w_addr] <= w_data;
  end
  assign r_data = mem4[r_addr];

  // eC = 3 instance
  logic       rst3_n, in3_valid, out3_ready;
  logic [7:0] in3_data;
  logic       in3_ready, out3_valid, w3_en, full3, empty3;
  logic [7:0] out3_data, w3_data, r3_data;
  logic [1:0] w3_addr, r3_addr, level3;
  logic [7:0] mem3 [4];

  fifo_ctrl #(.bW(8), .eC(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data),
    .out_valid(out3_valid), .out_ready(out3_ready), .out_data(out3_data),
    .writeAddr(w3_addr), .writeData(w3_data), .writeEn(w3_en),
    .readAddr(r3_addr), .readData(r3_data),
    .level(level3), .full(full3), .empty(empty3)
  );

  // Storage model for the eC=3 instance
  always_ff @(posedge clk) begin
    if (w3_en) mem3[w3_addr] <= w3_data;
  end
  assign r3_data = mem3[r3_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fill_v [4];
    fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      mem4[i] = 8'h00;
      mem3[i] = 8'h00;
    end

    // Reset both instances
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    rst3_n = 1'b0; in3_valid = 1'b0; in3_data = 8'h00; out3_ready = 1'b0;
    step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1; rst3_n = 1'b1;

    // Fill with out_ready low
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = fill_v[i];
      #1;
      chk("fill_wen", 32'(w_en), 32'd1);
      chk("fill_waddr", 32'(w_addr), 32'(i));
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);

    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'(fill_v[i]));
      step();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Push into empty: no bypass, visible one cycle later
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    chk("ebyp_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("ebyp_out_valid_next", 32'(out_valid), 32'd1);
    chk("ebyp_out_data", 32'(out_data), 32'h5A);
    step();
    chk("stall_out_data", 32'(out_data), 32'h5A);

    // Reach level 2, then push and pop together for 5 cycles
    in_valid = 1'b1; in_data = 8'h66;
    step();
    chk("pp_pre_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [7:0] head;
      head = (k == 0) ? 8'h5A : (k == 1) ? 8'h66 : 8'(8'h70 + k - 2);
      in_data = 8'(8'h70 + k);
      #1;
      chk("pp_wen", 32'(w_en), 32'd1);
      chk("pp_out_data", 32'(out_data), 32'(head));
      step();
      chk("pp_level", 32'(level), 32'd2);
    end

    // Refill to 4 (queue: 73 74 80 81)
    out_ready = 1'b0;
    in_data = 8'h80; step();
    in_data = 8'h81; step();
    chk("fp_pre_level", 32'(level), 32'd4);

    // Full plus pop: pop only this cycle, push accepted next cycle
    in_data = 8'h90; out_ready = 1'b1;
    #1;
    chk("fp_in_ready", 32'(in_ready), 32'd0);
    chk("fp_wen", 32'(w_en), 32'd0);
    chk("fp_out_data", 32'(out_data), 32'h73);
    step();
    chk("fp_level3", 32'(level), 32'd3);
    chk("fp_in_ready_back", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    #1;
    chk("fp_wen_next", 32'(w_en), 32'd1);
    step();
    chk("fp_level4", 32'(level), 32'd4);
    chk("fp_head", 32'(out_data), 32'h74);

    // Drop to level 3, then reset mid-operation with in_valid high
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("mr_pre_level", 32'(level), 32'd3);
    out_ready = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    #1;
    chk("mr_wen", 32'(w_en), 32'd0);
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_waddr", 32'(w_addr), 32'd0);

    // The first push after reset is accepted
    in_valid = 1'b1; in_data = 8'h3C;
    #1;
    chk("pr_wen", 32'(w_en), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk("pr_level", 32'(level), 32'd1);
    chk("pr_out_data", 32'(out_data), 32'h3C);

    // Wrap at eC=3: six pushes, each one after the first paired with a pop
    for (int k = 0; k < 6; k++) begin
      in3_valid = 1'b1; in3_data = 8'(8'hA0 + k); out3_ready = (k > 0);
      #1;
      chk("wrap_waddr", 32'(w3_addr), 32'(k % 3));
      chk("wrap_wen", 32'(w3_en), 32'd1);
      if (k > 0) chk("wrap_out_data", 32'(out3_data), 32'(8'hA0 + k - 1));
      step();
      chk("wrap_level", 32'(level3), 32'd1);
    end
    in3_valid = 1'b0; out3_ready = 1'b1;
    #1;
    chk("wrap_last_data", 32'(out3_data), 32'hA5);
    step();
    chk("wrap_empty", 32'(empty3), 32'd1);
    out3_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
